// File: rtl/mips_alu_stage.sv
// Execute-stage slice of a multicycle MIPS datapath: a combinational ALU with ALUOut and PC registers.
// Define MIPS_ALU_OVF_EN to add the combinational signed-overflow output.
module mips_alu_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [2:0]       aluControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zeroFlag,
    output logic [WIDTH-1:0] ALUOut,
    input  logic             pcEn,
    input  logic [WIDTH-1:0] pcNext,
    output logic [WIDTH-1:0] pc
`ifdef MIPS_ALU_OVF_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] sum_s;
    logic             slt_s;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] aluout_d;
    logic [WIDTH-1:0] aluout_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    // Operand B inversion plus carry-in turns the adder into a subtractor for codes 1xx.
    always_comb begin
        b_eff_s = aluControl[2] ? ~srcB : srcB;
        sum_s   = srcA + b_eff_s + {{(WIDTH-1){1'b0}}, aluControl[2]};
        slt_s   = ($signed(srcA) < $signed(srcB));
    end

    // Operation select.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        case (aluControl[1:0])
            2'b00:   result_s = srcA & b_eff_s;
            2'b01:   result_s = srcA | b_eff_s;
            2'b10:   result_s = sum_s;
            2'b11:   result_s = aluControl[2] ? {{(WIDTH-1){1'b0}}, slt_s} : {WIDTH{1'b0}};
            default: result_s = {WIDTH{1'b0}};
        endcase
    end

    assign ALUResult = result_s;
    assign zeroFlag  = ~(|result_s);

`ifdef MIPS_ALU_OVF_EN
    // Signed overflow of the add/subtract path; b_eff_s already carries the subtract inversion.
    always_comb begin
        overflow = 1'b0;
        case (aluControl)
            3'b010:  overflow = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum_s[WIDTH-1] != srcA[WIDTH-1]);
            3'b110:  overflow = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (sum_s[WIDTH-1] != srcA[WIDTH-1]);
            default: overflow = 1'b0;
        endcase
    end
`endif

    // Next-state for ALUOut (always loads) and PC (loads only when enabled).
    always_comb begin
        aluout_d = result_s;
        if (pcEn) begin
            pc_d = pcNext;
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers with synchronous active-low reset taking priority over loading.
    always_ff @(posedge clk) begin
        if (!reset) begin
            aluout_q <= {WIDTH{1'b0}};
            pc_q     <= PC_RESET;
        end else begin
            aluout_q <= aluout_d;
            pc_q     <= pc_d;
        end
    end

    assign ALUOut = aluout_q;
    assign pc     = pc_q;

endmodule

// File: tb/tb_mips_alu_stage.sv
// Directed, table-driven bench for mips_alu_stage; overflow checks are compiled in with MIPS_ALU_OVF_EN.
module tb_mips_alu_stage;

    logic        clk;
    logic        reset;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [2:0]  aluControl;
    logic [31:0] ALUResult;
    logic        zeroFlag;
    logic [31:0] ALUOut;
    logic        pcEn;
    logic [31:0] pcNext;
    logic [31:0] pc;
`ifdef MIPS_ALU_OVF_EN
    logic        overflow;
`endif

    int checks;
    int errors;

    mips_alu_stage #(.WIDTH(32), .PC_RESET(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .srcA       (srcA),
        .srcB       (srcB),
        .aluControl (aluControl),
        .ALUResult  (ALUResult),
        .zeroFlag   (zeroFlag),
        .ALUOut     (ALUOut),
        .pcEn       (pcEn),
        .pcNext     (pcNext),
        .pc         (pc)
`ifdef MIPS_ALU_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        zf;
        logic        ovf;
    } vec_t;

    vec_t vecs[16];
    int   nvec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [31:0] res, input logic zf, input logic ovf);
        vecs[nvec].a   = a;
        vecs[nvec].b   = b;
        vecs[nvec].op  = op;
        vecs[nvec].res = res;
        vecs[nvec].zf  = zf;
        vecs[nvec].ovf = ovf;
        nvec++;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        nvec       = 0;
        reset      = 1'b0;
        pcEn       = 1'b1;
        pcNext     = 32'h0000_0040;
        srcA       = 32'h0000_0001;
        srcB       = 32'h0000_0001;
        aluControl = 3'b010;

        add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 1'b0, 1'b0);
        add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0);
        add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 32'hF000_F000, 1'b0, 1'b0);
        add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b101, 32'hF0FF_F0FF, 1'b0, 1'b0);
        add_vec(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'h0000_0005, 32'h0000_0007, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0);
        add_vec(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1);
        add_vec(32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1);
        add_vec(32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b0);
        add_vec(32'h0000_0001, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h0000_0001, 1'b0, 1'b0);
        add_vec(32'h0000_0042, 32'h0000_0042, 3'b111, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'h0000_0003, 32'h0000_0004, 3'b010, 32'h0000_0007, 1'b0, 1'b0);

        // Reset wins over a pending PC load; release resumes loading.
        tick();
        check("reset_pc", pc, 32'h0000_0000);
        check("reset_aluout", ALUOut, 32'h0000_0000);
        reset = 1'b1;
        tick();
        check("post_reset_pc", pc, 32'h0000_0040);
        check("post_reset_aluout", ALUOut, 32'h0000_0002);

        pcEn = 1'b0;
        for (int i = 0; i < nvec; i++) begin
            srcA       = vecs[i].a;
            srcB       = vecs[i].b;
            aluControl = vecs[i].op;
            #1;
            check($sformatf("vec%0d_result", i), ALUResult, vecs[i].res);
            check($sformatf("vec%0d_zero", i), {31'b0, zeroFlag}, {31'b0, vecs[i].zf});
`ifdef MIPS_ALU_OVF_EN
            check($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
`endif
            tick();
            check($sformatf("vec%0d_aluout", i), ALUOut, vecs[i].res);
        end

        // PC load then hold for three edges while pcNext wanders.
        pcEn   = 1'b1;
        pcNext = 32'h0000_0010;
        tick();
        check("pc_load", pc, 32'h0000_0010);
        pcEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pcNext = 32'h0000_0100 + 32'(i);
            tick();
            check($sformatf("pc_hold%0d", i), pc, 32'h0000_0010);
        end

        // ALUOut latency and mid-cycle operand changes.
        aluControl = 3'b011;
        tick();
        check("lat_clear", ALUOut, 32'h0000_0000);
        srcA       = 32'h0000_0002;
        srcB       = 32'h0000_0003;
        aluControl = 3'b010;
        #1;
        check("lat_comb", ALUResult, 32'h0000_0005);
        check("lat_before_edge", ALUOut, 32'h0000_0000);
        tick();
        check("lat_after_edge", ALUOut, 32'h0000_0005);
        #2;
        srcA = 32'h0000_000A;
        srcB = 32'h0000_000A;
        #1;
        check("lat_midcycle_comb", ALUResult, 32'h0000_0014);
        check("lat_midcycle_hold", ALUOut, 32'h0000_0005);
        tick();
        check("lat_next_edge", ALUOut, 32'h0000_0014);

        // Mid-operation reset: no effect until the edge, then clears both registers.
        pcEn   = 1'b1;
        pcNext = 32'h0000_0080;
        tick();
        check("pre_reset_pc", pc, 32'h0000_0080);
        pcNext = 32'h0000_00C0;
        reset  = 1'b0;
        #2;
        check("reset_between_edges_pc", pc, 32'h0000_0080);
        check("reset_between_edges_aluout", ALUOut, 32'h0000_0014);
        tick();
        check("midreset_pc", pc, 32'h0000_0000);
        check("midreset_aluout", ALUOut, 32'h0000_0000);
        check("midreset_comb", ALUResult, 32'h0000_0014);
        reset = 1'b1;
        tick();
        check("resume_pc", pc, 32'h0000_00C0);
        check("resume_aluout", ALUOut, 32'h0000_0014);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_alu_stage.md
# mips_alu_stage

Execute-stage slice of the multicycle MIPS datapath: a combinational 32-bit ALU plus the two state registers around it. These are the ALU result register (ALUOut, always loaded) and the program-counter register (loaded only when enabled). The controller drives `aluControl` and `pcEn`. The surrounding datapath muxes supply the operands and the next-PC value.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width of operands, result, ALUOut and PC.
- `PC_RESET`, default 0: value loaded into PC on reset.

Ports:
- `clk`, input, 1: the block's only clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low. `reset`=0 at a rising `clk` edge clears state.
- `srcA`, input, WIDTH: ALU operand A.
- `srcB`, input, WIDTH: ALU operand B.
- `aluControl`, input, 3: operation select.
- `ALUResult`, output, WIDTH: combinational ALU result.
- `zeroFlag`, output, 1: high when `ALUResult` is all zeros (combinational).
- `ALUOut`, output, WIDTH: registered `ALUResult`.
- `pcEn`, input, 1: PC load enable.
- `pcNext`, input, WIDTH: next PC value.
- `pc`, output, WIDTH: registered PC.
- `overflow`, output, 1: present only with `MIPS_ALU_OVF_EN`.

## Operation
`aluControl` encoding; B' means B for codes 0xx and ~B for codes 1xx:
- 000: A & B
- 001: A | B
- 010: A + B
- 011: constant 0
- 100: A & ~B
- 101: A | ~B
- 110: A − B
- 111: SLT. Result is 1 if A < B as signed two's complement, else 0; upper WIDTH−1 bits are zero.

Arithmetic and flag rules:
- Add and subtract are modulo 2^WIDTH. Carry out is discarded.
- SLT uses a true signed comparison. It is correct even when A − B overflows, e.g. A=0x7FFFFFFF, B=0x80000000 gives 0.
- `zeroFlag` equals NOR of all `ALUResult` bits, for every opcode including 011.

Register rules:
- ALUOut register: unconditionally captures `ALUResult` each edge. Reset clears it to 0.
- PC register: captures `pcNext` when `pcEn`=1, otherwise holds. Reset loads `PC_RESET`.
- Reset has priority over `pcEn`.

## Timing
- `ALUResult` and `zeroFlag` are purely combinational from `srcA`, `srcB` and `aluControl`, with zero latency.
- `ALUOut` has 1-cycle latency. The value present at edge N is visible after edge N, through the next edge.
- `pc` updates on the edge where `pcEn`=1. With `pcEn`=0 it holds indefinitely.
- Reset is synchronous. Asserting `reset`=0 between edges changes nothing until the next rising edge.
- Reset asserted mid-operation overrides any pending load: after that edge `ALUOut`=0 and `pc`=`PC_RESET`.
- The first edge with `reset`=1 resumes normal loading of both registers.
- Reset values: `ALUOut`=0 and `pc`=`PC_RESET`. `ALUResult`, `zeroFlag` and `overflow` follow inputs and are not reset.

## Configuration
- `MIPS_ALU_OVF_EN` defined: the `overflow` output exists.
  - Add (010): high when A and B have equal sign bits and the result sign differs from them.
  - Subtract (110): high when A and B have different sign bits and the result sign differs from A.
  - All other codes: 0.
  - The output is combinational, not registered.
- `MIPS_ALU_OVF_EN` undefined: no `overflow` port and no overflow logic. All other behaviour is identical.

## Test plan
- Reset with `reset`=0 for one edge while `pcEn`=1, `pcNext`=0x40 → `pc`=0 and `ALUOut`=0 after the edge. Release reset, next edge → `pc`=0x40.
- Logic ops with A=0xF0F0F0F0, B=0x0FF00FF0:
  - 000 → 0x00F000F0
  - 001 → 0xFFF0FFF0
  - 100 → 0xF000F000
  - 101 → 0xF0FFF0FF
  - 011 → 0 with `zeroFlag`=1
- Arithmetic: 010 with 0xFFFFFFFF+1 → 0, `zeroFlag`=1, `overflow`=0. 110 with 5−7 → 0xFFFFFFFE. With the macro, 010 with 0x7FFFFFFF+1 → `overflow`=1.
- SLT: A=−1, B=1 → 1. A=1, B=−1 → 0. A=0x7FFFFFFF, B=0x80000000 → 0. A=B → 0.
- PC enable: load 0x10 with `pcEn`=1, then hold `pcEn`=0 for 3 edges while `pcNext` changes → `pc` stays 0x10.
- ALUOut latency: apply 2+3 with op 010 → `ALUResult`=5 immediately and `ALUOut`=5 only after the next edge. Changing operands mid-cycle does not affect `ALUOut` until the following edge.
